// File: rtl/ball_physics.sv
// Pong ball motion engine: serve delay, wall and paddle bounces, hit-offset
// steering, periodic horizontal speed-up and score pulses on misses.
module ball_physics #(
    parameter int HOR_PIXELS       = 1024,
    parameter int VER_PIXELS       = 768,
    parameter int BALL_SIZE        = 15,
    parameter int X_PAD_L          = 30,
    parameter int X_PAD_R          = 979,
    parameter int PAD_WIDTH        = 15,
    parameter int PAD_HEIGHT       = 145,
    parameter int V_INIT           = 2,
    parameter int V_MAX            = 7,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int SERVE_TICKS      = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        game_active,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_ball,
    output logic [9:0]  y_ball,
    output logic        hit,
    output logic        point_left,
    output logic        point_right
);
    localparam logic [10:0] X_CTR    = 11'((HOR_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CTR    = 10'((VER_PIXELS - BALL_SIZE) / 2);
    localparam logic [11:0] X_LIM    = 12'(HOR_PIXELS - BALL_SIZE);
    localparam logic [11:0] Y_LIM    = 12'(VER_PIXELS - BALL_SIZE);
    localparam logic [9:0]  Y_LIM_10 = 10'(VER_PIXELS - BALL_SIZE);
    localparam logic [11:0] BS       = 12'(BALL_SIZE);
    localparam logic [11:0] PH       = 12'(PAD_HEIGHT);
    localparam logic [11:0] PAD_R    = 12'(X_PAD_R);
    localparam logic [11:0] FACE_L   = 12'(X_PAD_L + PAD_WIDTH);
    localparam logic [10:0] X_HIT_R  = 11'(X_PAD_R - BALL_SIZE);
    localparam logic [10:0] X_HIT_L  = 11'(X_PAD_L + PAD_WIDTH);
    localparam logic [11:0] BS_HALF  = 12'(BALL_SIZE / 2);
    localparam logic [11:0] PH_HALF  = 12'(PAD_HEIGHT / 2);
    localparam logic [11:0] ZONE_1   = 12'(PAD_HEIGHT / 6);
    localparam logic [11:0] ZONE_2   = 12'(PAD_HEIGHT / 3);
    localparam logic [2:0]  VX_INIT  = 3'(V_INIT);
    localparam logic [2:0]  VX_MAX   = 3'(V_MAX);
    localparam logic [7:0]  HIT_WRAP = 8'(HITS_PER_SPEEDUP);
    localparam logic [15:0] SRV_LAST = 16'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORED} state_t;

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        dir_r_q, dir_r_d, dir_d_q, dir_d_d;
    logic [2:0]  vx_q, vx_d;
    logic [1:0]  vy_q, vy_d;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic [15:0] srv_cnt_q, srv_cnt_d;
    logic        hit_q, hit_d, point_left_q, point_left_d, point_right_q, point_right_d;

    logic [11:0] x_s, y_s, vx_s, vy_s, pl_s, pr_s, d_s, d_abs_s;
    logic        ov_l_s, ov_r_s, hit_r_s, hit_l_s, miss_r_s, miss_l_s, dir_d_mv_s;
    logic [9:0]  y_mv_s;
    logic [1:0]  vy_hit_s;
    logic [7:0]  hit_cnt_inc_s;
    logic [2:0]  vx_up_s;

    // Collision, offset and wall-bounce datapath, all in 12-bit unsigned
    always_comb begin
        x_s  = {1'b0, x_q};
        y_s  = {2'b00, y_q};
        vx_s = {9'd0, vx_q};
        vy_s = {10'd0, vy_q};
        pl_s = {2'b00, y_pad_left};
        pr_s = {2'b00, y_pad_right};
        ov_l_s   = ((y_s + BS) >= pl_s) && (y_s <= (pl_s + PH));
        ov_r_s   = ((y_s + BS) >= pr_s) && (y_s <= (pr_s + PH));
        hit_r_s  = dir_r_q && ((x_s + BS) <= PAD_R) && ((x_s + BS + vx_s) >= PAD_R) && ov_r_s;
        miss_r_s = dir_r_q && !hit_r_s && ((x_s + vx_s) >= X_LIM);
        hit_l_s  = !dir_r_q && (x_s >= FACE_L) && (x_s <= (FACE_L + vx_s)) && ov_l_s;
        miss_l_s = !dir_r_q && !hit_l_s && (x_s < vx_s);
        // Two's-complement offset of ball centre from paddle centre
        d_s     = (y_s + BS_HALF) - ((dir_r_q ? pr_s : pl_s) + PH_HALF);
        d_abs_s = d_s[11] ? (12'd0 - d_s) : d_s;
        if (d_abs_s < ZONE_1) begin
            vy_hit_s = 2'd1;
        end else if (d_abs_s < ZONE_2) begin
            vy_hit_s = 2'd2;
        end else begin
            vy_hit_s = 2'd3;
        end
        hit_cnt_inc_s = hit_cnt_q + 8'd1;
        vx_up_s       = (vx_q < VX_MAX) ? (vx_q + 3'd1) : VX_MAX;
        if (dir_d_q) begin
            if ((y_s + vy_s) >= Y_LIM) begin
                y_mv_s     = Y_LIM_10;
                dir_d_mv_s = 1'b0;
            end else begin
                y_mv_s     = 10'(y_s + vy_s);
                dir_d_mv_s = 1'b1;
            end
        end else begin
            if (y_s < vy_s) begin
                y_mv_s     = 10'd0;
                dir_d_mv_s = 1'b1;
            end else begin
                y_mv_s     = 10'(y_s - vy_s);
                dir_d_mv_s = 1'b0;
            end
        end
    end

    // Next-state and next-register logic; stopping the game overrides everything
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        dir_r_d       = dir_r_q;
        dir_d_d       = dir_d_q;
        vx_d          = vx_q;
        vy_d          = vy_q;
        hit_cnt_d     = hit_cnt_q;
        srv_cnt_d     = srv_cnt_q;
        hit_d         = 1'b0;
        point_left_d  = 1'b0;
        point_right_d = 1'b0;
        if (!game_active) begin
            state_d   = IDLE;
            x_d       = X_CTR;
            y_d       = Y_CTR;
            dir_r_d   = 1'b0;
            dir_d_d   = 1'b0;
            vx_d      = VX_INIT;
            vy_d      = 2'd1;
            hit_cnt_d = 8'd0;
            srv_cnt_d = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SERVE;
                    srv_cnt_d = 16'd0;
                end
                SERVE: begin
                    if (timing_tick && (srv_cnt_q == SRV_LAST)) begin
                        srv_cnt_d = 16'd0;
                        state_d   = MOVE;
                    end else if (timing_tick) begin
                        srv_cnt_d = srv_cnt_q + 16'd1;
                    end else begin
                        srv_cnt_d = srv_cnt_q;
                    end
                end
                MOVE: begin
                    if (timing_tick) begin
                        y_d     = y_mv_s;
                        dir_d_d = dir_d_mv_s;
                        if (hit_r_s || hit_l_s) begin
                            x_d     = hit_r_s ? X_HIT_R : X_HIT_L;
                            dir_r_d = hit_l_s;
                            hit_d   = 1'b1;
                            vy_d    = vy_hit_s;
                            dir_d_d = !d_s[11];
                            if (hit_cnt_inc_s == HIT_WRAP) begin
                                hit_cnt_d = 8'd0;
                                vx_d      = vx_up_s;
                            end else begin
                                hit_cnt_d = hit_cnt_inc_s;
                            end
                        end else if (miss_r_s || miss_l_s) begin
                            // Re-centre now so the ball is home while the pulse shows
                            point_left_d  = miss_r_s;
                            point_right_d = miss_l_s;
                            x_d       = X_CTR;
                            y_d       = Y_CTR;
                            vx_d      = VX_INIT;
                            vy_d      = 2'd1;
                            hit_cnt_d = 8'd0;
                            dir_r_d   = miss_r_s;
                            state_d   = SCORED;
                        end else if (dir_r_q) begin
                            x_d = 11'(x_s + vx_s);
                        end else begin
                            x_d = 11'(x_s - vx_s);
                        end
                    end else begin
                        state_d = MOVE;
                    end
                end
                SCORED: begin
                    x_d       = X_CTR;
                    y_d       = Y_CTR;
                    vx_d      = VX_INIT;
                    vy_d      = 2'd1;
                    hit_cnt_d = 8'd0;
                    srv_cnt_d = 16'd0;
                    dir_r_d   = point_left_q;
                    state_d   = SERVE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            x_q           <= X_CTR;
            y_q           <= Y_CTR;
            dir_r_q       <= 1'b0;
            dir_d_q       <= 1'b0;
            vx_q          <= VX_INIT;
            vy_q          <= 2'd1;
            hit_cnt_q     <= 8'd0;
            srv_cnt_q     <= 16'd0;
            hit_q         <= 1'b0;
            point_left_q  <= 1'b0;
            point_right_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            dir_r_q       <= dir_r_d;
            dir_d_q       <= dir_d_d;
            vx_q          <= vx_d;
            vy_q          <= vy_d;
            hit_cnt_q     <= hit_cnt_d;
            srv_cnt_q     <= srv_cnt_d;
            hit_q         <= hit_d;
            point_left_q  <= point_left_d;
            point_right_q <= point_right_d;
        end
    end

    assign x_ball      = x_q;
    assign y_ball      = y_q;
    assign hit         = hit_q;
    assign point_left  = point_left_q;
    assign point_right = point_right_q;
endmodule

// File: tb/tb_ball_physics.sv
// Bench for ball_physics: a cycle model queues expected outputs per clock,
// directed checks cover serve timing, stop, miss, speed-up and off-centre hits.
module tb_ball_physics;
    logic        clk = 1'b0;
    logic        rst, timing_tick, game_active;
    logic [9:0]  y_pad_left, y_pad_right;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic        hit, point_left, point_right;

    ball_physics dut (
        .clk(clk), .rst(rst), .timing_tick(timing_tick), .game_active(game_active),
        .y_pad_left(y_pad_left), .y_pad_right(y_pad_right),
        .x_ball(x_ball), .y_ball(y_ball),
        .hit(hit), .point_left(point_left), .point_right(point_right)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];

    // Reference model state (0 idle, 1 serve, 2 move, 3 scored)
    int m_state, m_x, m_y, m_dr, m_dd, m_vx, m_vy, m_hc, m_srv, m_last_pl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_idle();
        m_x = 504; m_y = 376; m_dr = 0; m_dd = 0;
        m_vx = 2; m_vy = 1; m_hc = 0; m_srv = 0;
    endtask

    task automatic model_step();
        int nx, ny, ndd, ndr, p, d, ad, pl, pr;
        bit ovl, ovr, hr, hl, e_hit, e_pl, e_pr;
        e_hit = 1'b0; e_pl = 1'b0; e_pr = 1'b0;
        pl = int'(y_pad_left);
        pr = int'(y_pad_right);
        if (rst || !game_active) begin
            model_idle();
            m_state = 0;
        end else begin
            case (m_state)
                0: begin model_idle(); m_state = 1; end
                1: begin
                    if (timing_tick) begin
                        if (m_srv == 59) begin m_srv = 0; m_state = 2; end
                        else m_srv++;
                    end
                end
                2: begin
                    if (timing_tick) begin
                        nx = m_x; ny = m_y; ndd = m_dd; ndr = m_dr;
                        if (m_dd == 1) begin
                            if (m_y + m_vy >= 753) begin ny = 753; ndd = 0; end
                            else ny = m_y + m_vy;
                        end else begin
                            if (m_y < m_vy) begin ny = 0; ndd = 1; end
                            else ny = m_y - m_vy;
                        end
                        ovl = (m_y + 15 >= pl) && (m_y <= pl + 145);
                        ovr = (m_y + 15 >= pr) && (m_y <= pr + 145);
                        hr  = (m_dr == 1) && (m_x + 15 <= 979) && (m_x + 15 + m_vx >= 979) && ovr;
                        hl  = (m_dr == 0) && (m_x >= 45) && (m_x <= 45 + m_vx) && ovl;
                        if (hr || hl) begin
                            e_hit = 1'b1;
                            p   = hr ? pr : pl;
                            nx  = hr ? 964 : 45;
                            ndr = hr ? 0 : 1;
                            d   = (m_y + 7) - (p + 72);
                            ad  = (d < 0) ? -d : d;
                            m_vy = (ad < 24) ? 1 : ((ad < 48) ? 2 : 3);
                            ndd = (d >= 0) ? 1 : 0;
                            m_hc++;
                            if (m_hc == 4) begin
                                m_hc = 0;
                                if (m_vx < 7) m_vx++;
                            end
                        end else if ((m_dr == 1 && m_x + m_vx >= 1009) || (m_dr == 0 && m_x < m_vx)) begin
                            e_pl = (m_dr == 1);
                            e_pr = (m_dr == 0);
                            nx = 504; ny = 376; m_vx = 2; m_vy = 1; m_hc = 0;
                            ndr = e_pl ? 1 : 0;
                            m_last_pl = e_pl ? 1 : 0;
                            m_state = 3;
                        end else begin
                            nx = (m_dr == 1) ? m_x + m_vx : m_x - m_vx;
                        end
                        m_x = nx; m_y = ny; m_dd = ndd; m_dr = ndr;
                    end
                end
                default: begin
                    m_x = 504; m_y = 376; m_vx = 2; m_vy = 1; m_hc = 0; m_srv = 0;
                    m_dr = m_last_pl;
                    m_state = 1;
                end
            endcase
        end
        exp_q.push_back({11'(m_x), 10'(m_y), e_hit, e_pl, e_pr});
    endtask

    // One clock: model predicts, DUT steps, scoreboard compares
    task automatic step();
        logic [23:0] e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("cycle", {8'd0, x_ball, y_ball, hit, point_left, point_right}, {8'd0, e});
    endtask

    // Paddle modes: 0 far from ball, 1 centred on ball, 2 right paddle top at ball top
    task automatic drive(input int pmode, input bit rnd);
        int pc;
        pc = (m_y >= 65) ? m_y - 65 : 0;
        case (pmode)
            0: begin
                y_pad_left  = (m_y < 384) ? 10'd600 : 10'd0;
                y_pad_right = (m_y < 384) ? 10'd600 : 10'd0;
            end
            1: begin
                y_pad_left  = 10'(pc);
                y_pad_right = 10'(pc);
            end
            default: begin
                y_pad_left  = 10'(pc);
                y_pad_right = 10'(m_y);
            end
        endcase
        timing_tick = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
    endtask

    // From IDLE or SCORED with a tick every cycle: 60 serve ticks, then one move left
    task automatic check_serve();
        timing_tick = 1'b1;
        repeat (61) step();
        check_eq("serve_hold_x", 32'(x_ball), 32'd504);
        step();
        check_eq("serve_move_x", 32'(x_ball), 32'd502);
    endtask

    initial begin
        int nh, xh, yh, guard, stepsz, seen;
        rst = 1'b1; game_active = 1'b1; timing_tick = 1'b1;
        y_pad_left = 10'd0; y_pad_right = 10'd0;
        model_idle();
        m_state = 0; m_last_pl = 0;
        repeat (3) step();
        check_eq("rst_x", 32'(x_ball), 32'd504);
        check_eq("rst_y", 32'(y_ball), 32'd376);
        check_eq("rst_pulses", 32'({hit, point_left, point_right}), 32'd0);
        rst = 1'b0;
        check_serve();

        repeat (10) drive(1, 1'b0);
        game_active = 1'b0;
        step();
        check_eq("stop_x", 32'(x_ball), 32'd504);
        check_eq("stop_y", 32'(y_ball), 32'd376);
        check_eq("stop_pulses", 32'({hit, point_left, point_right}), 32'd0);
        game_active = 1'b1;
        check_serve();

        seen = 0; guard = 0;
        while (seen == 0 && guard < 3000) begin
            drive(0, 1'b1);
            guard++;
            if (point_right) seen = 1;
        end
        check_eq("miss_pulse", 32'(seen), 32'd1);
        check_eq("miss_x", 32'(x_ball), 32'd504);
        check_eq("miss_y", 32'(y_ball), 32'd376);
        check_eq("miss_side", 32'(point_left), 32'd0);
        check_serve();

        nh = 0; guard = 0;
        while (nh < 24 && guard < 40000) begin
            drive(1, 1'b0);
            guard++;
            if (hit) begin
                nh++;
                xh = int'(x_ball);
                drive(1, 1'b0);
                guard++;
                stepsz = (int'(x_ball) > xh) ? int'(x_ball) - xh : xh - int'(x_ball);
                check_eq("vx_after_hit", 32'(stepsz), 32'((2 + nh / 4 > 7) ? 7 : 2 + nh / 4));
            end
        end
        check_eq("rally_hits", 32'(nh), 32'd24);

        nh = 0; guard = 0;
        while (nh < 2 && guard < 5000) begin
            drive(2, 1'b0);
            guard++;
            if (hit && x_ball == 11'd964) begin
                nh++;
                yh = int'(y_ball);
                drive(2, 1'b0);
                guard++;
                check_eq("offhit_x", 32'(x_ball), 32'd957);
                check_eq("offhit_y", 32'(y_ball), 32'((yh >= 3) ? yh - 3 : 0));
            end
        end
        check_eq("offhit_count", 32'(nh), 32'd2);

        rst = 1'b1;
        step();
        check_eq("rst_mid", 32'({x_ball, y_ball, hit, point_left, point_right}),
                 32'({11'd504, 10'd376, 3'd0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
